pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the iCE40 PLL. Runs on the PLL output clock and consumes the PLL lock indication.
- Qualifies lock, waits for a stability window, then releases up to NUM_STAGES design resets in order (e.g. SDRAM controller, then video, then CPU), one gap apart.
- Re-asserts all resets on lock loss or on a software reset request.
- Keeps a saturating lock-loss counter for debug LEDs or UART.

Parameters:
- STABLE_CYCLES, 1024: consecutive synchronised-lock cycles required before release; >=2.
- STAGE_GAP, 16: clock edges between successive stage releases; >=1.
- NUM_STAGES, 3: number of staged reset outputs; 1..8.
- SYNC_STAGES, 2: flip-flops in the pll_lock synchroniser; >=2.
- SWRST_CYCLES, 64: cycles all resets are held low after a software request; >=1.

Ports:
- clock, in, 1: PLL output clock (the single clock domain).
- reset_n, in, 1: synchronous active-low reset.
- pll_lock, in, 1: PLL LOCK, asynchronous to clock.
- sw_reset_req, in, 1: level, sampled each edge; software reset request.
- rst_out_n, out, NUM_STAGES: staged active-low resets; bit 0 is released first.
- ready, out, 1: high when all stages are released.
- state, out, 3: current FSM state, for debug.
- lock_lost_count, out, 8: saturating count of lock-loss events.

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-low (reset_n).
- Reset (reset_n=0 at an edge):
  - rst_out_n=0, ready=0, state=WAIT_LOCK, lock_lost_count=0.
  - Synchroniser flops cleared; all counters cleared.
- All outputs are registered.
- Synchroniser: lock_s is pll_lock delayed through SYNC_STAGES flops. No other logic samples pll_lock directly.
- State encoding: WAIT_LOCK=0, STABILIZE=1, RELEASE=2, RUN=3, HOLD=4. Codes 5..7 go to WAIT_LOCK.
- WAIT_LOCK:
  - rst_out_n all 0, ready 0.
  - lock_s=1 -> STABILIZE, cnt=0.
  - sw_reset_req is ignored.
- STABILIZE:
  - lock_s=0 -> WAIT_LOCK. This is not counted as a loss.
  - Otherwise cnt++.
  - When cnt==STABLE_CYCLES-1 and lock_s=1 -> RELEASE, stage index=0, gap cnt=0.
  - sw_reset_req is ignored.
- RELEASE:
  - First edge in RELEASE sets rst_out_n[0]=1.
  - Each subsequent stage k is set STAGE_GAP edges after stage k-1.
  - Released bits stay 1.
  - The edge that releases bit NUM_STAGES-1 also sets ready=1 and moves to RUN.
  - With NUM_STAGES=1: the release and the RUN transition occur on the same single edge.
- RUN: holds all ones and ready=1.
- Lock loss (lock_s=0 in RELEASE, RUN or HOLD):
  - On that edge: rst_out_n all 0, ready 0, state WAIT_LOCK.
  - lock_lost_count++, saturating at 255.
- Software request (sw_reset_req=1 in RELEASE or RUN, with lock_s=1):
  - On that edge: rst_out_n all 0, ready 0, state HOLD, cnt=0.
- HOLD:
  - cnt++ each edge.
  - When cnt==SWRST_CYCLES-1 and sw_reset_req=0 -> RELEASE. No re-stabilisation.
  - If sw_reset_req is still 1 at that point, stay in HOLD with cnt saturated until it drops.
- Priority within any single edge: reset_n > lock loss > sw_reset_req > normal progression.
- Glitch-free requirement: rst_out_n bits change only via the registered update. They never toggle while state is RUN and lock_s=1.

Test Plan (STABLE_CYCLES=8, STAGE_GAP=4, NUM_STAGES=3, SYNC_STAGES=2, SWRST_CYCLES=5; edges numbered from 1 at the first edge sampling pll_lock=1):
- Cold start: reset_n low 3 cycles, then high; pll_lock rises.
  -> Edge 3: state=1.
  -> Edge 12: rst_out_n=001.
  -> Edge 16: rst_out_n=011.
  -> Edge 20: rst_out_n=111, ready=1, state=3.
- Lock glitch during STABILIZE: pll_lock low for 1 cycle at edge 6.
  -> state returns to 0, lock_lost_count stays 0.
  -> Full 8-cycle window restarts after lock_s returns.
  -> rst_out_n stays 000 throughout.
- Lock loss in RUN: drop pll_lock.
  -> 2 edges later rst_out_n=000, ready=0, state=0, lock_lost_count=1.
  -> After 256 such losses the count reads 255.
- Software reset: 1-cycle sw_reset_req pulse in RUN.
  -> Next edge: rst_out_n=000, state=4.
  -> Edge 6 after the request edge: rst_out_n=001.
  -> Then 011 and 111 at +4 and +8 edges.
- Simultaneous events: sw_reset_req=1 on the same edge that lock_s falls.
  -> state=0 (not 4), lock_lost_count increments.
  -> Holding sw_reset_req high 20 cycles in HOLD keeps rst_out_n=000 until it drops.
- Mid-operation reset: reset_n=0 during RELEASE at rst_out_n=011.
  -> Same edge: rst_out_n=000, count=0, state=0.
  -> After reset_n returns high with pll_lock steady, the release recurs at edge 12 relative to the first post-reset edge.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock, waits a stability window, then releases staged active-low resets one gap apart.
// All outputs registered; lock loss or a software request re-asserts every reset on the sampling edge.
module pll_reset_sequencer #(
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGE_GAP     = 16,
  parameter int NUM_STAGES    = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int SWRST_CYCLES  = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  pll_lock,
  input  logic                  sw_reset_req,
  output logic [NUM_STAGES-1:0] rst_out_n,
  output logic                  ready,
  output logic [2:0]            state,
  output logic [7:0]            lock_lost_count
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABILIZE = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    HOLD      = 3'd4
  } state_t;

  localparam int CNT_MAX = (STABLE_CYCLES > SWRST_CYCLES) ? STABLE_CYCLES : SWRST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int GAP_W   = $clog2(STAGE_GAP + 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SWRST_LAST  = CNT_W'(SWRST_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(STAGE_GAP - 1);
  localparam logic [2:0]       LAST_IDX    = 3'(NUM_STAGES - 1);

  state_t                 st;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [CNT_W-1:0]       cnt;
  logic [GAP_W-1:0]       gap_cnt;
  logic [2:0]             stage_idx;
  logic                   locked_phase;

  assign lock_s       = sync_q[SYNC_STAGES-1];
  assign state        = st;
  assign locked_phase = (st == RELEASE) || (st == RUN) || (st == HOLD);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q          <= '0;
      st              <= WAIT_LOCK;
      rst_out_n       <= '0;
      ready           <= 1'b0;
      lock_lost_count <= '0;
      cnt             <= '0;
      gap_cnt         <= '0;
      stage_idx       <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
      if (locked_phase && !lock_s) begin
        st        <= WAIT_LOCK;
        rst_out_n <= '0;
        ready     <= 1'b0;
        if (lock_lost_count != 8'hFF) lock_lost_count <= lock_lost_count + 8'd1;
      end else if (sw_reset_req && ((st == RELEASE) || (st == RUN))) begin
        st        <= HOLD;
        rst_out_n <= '0;
        ready     <= 1'b0;
        cnt       <= '0;
      end else begin
        case (st)
          WAIT_LOCK: begin
            rst_out_n <= '0;
            ready     <= 1'b0;
            if (lock_s) begin
              st  <= STABILIZE;
              cnt <= '0;
            end
          end
          STABILIZE: begin
            if (!lock_s) begin
              st <= WAIT_LOCK;
            end else if (cnt == STABLE_LAST) begin
              st        <= RELEASE;
              stage_idx <= '0;
              gap_cnt   <= GAP_LAST;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          // gap_cnt is preloaded to its terminal value so the first RELEASE edge frees stage 0.
          RELEASE: begin
            if (gap_cnt == GAP_LAST) begin
              rst_out_n <= rst_out_n | (NUM_STAGES'(1) << stage_idx);
              gap_cnt   <= '0;
              if (stage_idx == LAST_IDX) begin
                st    <= RUN;
                ready <= 1'b1;
              end else begin
                stage_idx <= stage_idx + 3'd1;
              end
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          RUN: begin
            ready <= 1'b1;
          end
          HOLD: begin
            if (cnt == SWRST_LAST) begin
              if (!sw_reset_req) begin
                st        <= RELEASE;
                stage_idx <= '0;
                gap_cnt   <= GAP_LAST;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            st        <= WAIT_LOCK;
            rst_out_n <= '0;
            ready     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with a small parameter set so every edge can be counted by hand.
module tb_pll_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       pll_lock;
  logic       sw_reset_req;
  logic [2:0] rst_out_n;
  logic       ready;
  logic [2:0] state;
  logic [7:0] lock_lost_count;

  int n_checks = 0;
  int n_fail   = 0;

  pll_reset_sequencer #(
    .STABLE_CYCLES(8),
    .STAGE_GAP    (4),
    .NUM_STAGES   (3),
    .SYNC_STAGES  (2),
    .SWRST_CYCLES (5)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .pll_lock       (pll_lock),
    .sw_reset_req   (sw_reset_req),
    .rst_out_n      (rst_out_n),
    .ready          (ready),
    .state          (state),
    .lock_lost_count(lock_lost_count)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] e_rst, input logic e_rdy,
                         input logic [2:0] e_st, input logic [7:0] e_cnt);
    chk({tag, "_rst"},   32'(rst_out_n),       32'(e_rst));
    chk({tag, "_ready"}, 32'(ready),           32'(e_rdy));
    chk({tag, "_state"}, 32'(state),           32'(e_st));
    chk({tag, "_count"}, 32'(lock_lost_count), 32'(e_cnt));
  endtask

  initial begin
    reset_n      = 1'b0;
    pll_lock     = 1'b0;
    sw_reset_req = 1'b0;

    // Cold start
    step(3);
    chk_all("reset", 3'b000, 1'b0, 3'd0, 8'd0);
    reset_n  = 1'b1;
    pll_lock = 1'b1;
    step(2);
    chk("cold_e2_state", 32'(state), 32'd0);
    step(1);
    chk_all("cold_e3", 3'b000, 1'b0, 3'd1, 8'd0);
    step(8);
    chk_all("cold_e11", 3'b000, 1'b0, 3'd2, 8'd0);
    step(1);
    chk_all("cold_e12", 3'b001, 1'b0, 3'd2, 8'd0);
    step(3);
    chk("cold_e15_rst", 32'(rst_out_n), 32'b001);
    step(1);
    chk_all("cold_e16", 3'b011, 1'b0, 3'd2, 8'd0);
    step(3);
    chk_all("cold_e19", 3'b011, 1'b0, 3'd2, 8'd0);
    step(1);
    chk_all("cold_e20", 3'b111, 1'b1, 3'd3, 8'd0);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("run_steady_rst", 32'(rst_out_n), 32'b111);
    end

    // Lock loss in RUN
    pll_lock = 1'b0;
    step(2);
    chk_all("loss_e2", 3'b111, 1'b1, 3'd3, 8'd0);
    step(1);
    chk_all("loss_e3", 3'b000, 1'b0, 3'd0, 8'd1);

    // Lock glitch during STABILIZE
    pll_lock = 1'b1;
    step(3);
    chk("glitch_e3_state", 32'(state), 32'd1);
    step(2);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(1);
    chk("glitch_e7_state", 32'(state), 32'd1);
    step(1);
    chk_all("glitch_e8", 3'b000, 1'b0, 3'd0, 8'd1);
    step(1);
    chk_all("glitch_e9", 3'b000, 1'b0, 3'd1, 8'd1);
    step(8);
    chk_all("glitch_e17", 3'b000, 1'b0, 3'd2, 8'd1);
    step(1);
    chk("glitch_e18_rst", 32'(rst_out_n), 32'b001);
    step(8);
    chk_all("glitch_e26", 3'b111, 1'b1, 3'd3, 8'd1);

    // Software reset pulse in RUN
    sw_reset_req = 1'b1;
    step(1);
    chk_all("sw_req", 3'b000, 1'b0, 3'd4, 8'd1);
    sw_reset_req = 1'b0;
    step(4);
    chk_all("sw_p4", 3'b000, 1'b0, 3'd4, 8'd1);
    step(1);
    chk_all("sw_p5", 3'b000, 1'b0, 3'd2, 8'd1);
    step(1);
    chk("sw_p6_rst", 32'(rst_out_n), 32'b001);
    step(4);
    chk("sw_p10_rst", 32'(rst_out_n), 32'b011);
    step(4);
    chk_all("sw_p14", 3'b111, 1'b1, 3'd3, 8'd1);

    // Simultaneous lock loss and software request
    pll_lock = 1'b0;
    step(2);
    sw_reset_req = 1'b1;
    step(1);
    chk_all("simul", 3'b000, 1'b0, 3'd0, 8'd2);
    sw_reset_req = 1'b0;

    // Software request held high across HOLD
    pll_lock = 1'b1;
    step(20);
    chk_all("relock", 3'b111, 1'b1, 3'd3, 8'd2);
    sw_reset_req = 1'b1;
    step(1);
    chk("hold_enter_state", 32'(state), 32'd4);
    for (int i = 0; i < 19; i++) begin
      step(1);
      chk("hold_held_rst", 32'(rst_out_n), 32'b000);
    end
    chk("hold_held_state", 32'(state), 32'd4);
    sw_reset_req = 1'b0;
    step(1);
    chk_all("hold_drop", 3'b000, 1'b0, 3'd2, 8'd2);
    step(1);
    chk("hold_rel0", 32'(rst_out_n), 32'b001);
    step(4);
    chk("hold_rel1", 32'(rst_out_n), 32'b011);

    // Mid-operation reset during RELEASE
    reset_n = 1'b0;
    step(1);
    chk_all("midrst", 3'b000, 1'b0, 3'd0, 8'd0);
    reset_n = 1'b1;
    step(11);
    chk_all("midrst_e11", 3'b000, 1'b0, 3'd2, 8'd0);
    step(1);
    chk("midrst_e12_rst", 32'(rst_out_n), 32'b001);
    step(8);
    chk_all("midrst_e20", 3'b111, 1'b1, 3'd3, 8'd0);

    // Saturating loss counter
    for (int n = 1; n <= 256; n++) begin
      pll_lock = 1'b0;
      step(3);
      if (n == 1)   chk("sat_first", 32'(lock_lost_count), 32'd1);
      if (n == 255) chk("sat_255",   32'(lock_lost_count), 32'd255);
      pll_lock = 1'b1;
      for (int c = 0; c < 40 && !ready; c++) step(1);
      chk("sat_relock_ready", 32'(ready), 32'd1);
    end
    chk("sat_256", 32'(lock_lost_count), 32'd255);
    pll_lock = 1'b0;
    step(3);
    chk_all("sat_257", 3'b000, 1'b0, 3'd0, 8'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
